// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_pkg
// Description : Shared encodings and constants for the iterative divider.
//               Holds the FSM state encodings and the divide-by-zero
//               quotient pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // Quotient returned for any divide by zero at the default 32-bit width
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = DIV_IDLE,
        ST_CALC = DIV_CALC,
        ST_DONE = DIV_DONE
    } div_state_t;

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring iteration. Shifts the
//               next dividend bit into the partial remainder and subtracts
//               the divisor when the trial result is non-negative.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    // The shifted remainder is kept one bit wider than the operands: with a
    // divisor above 2^(WIDTH-1) the remainder's top bit is still significant.
    logic [WIDTH:0] w_shift;

    assign w_shift = {i_rem, i_dvd_bit};

    // Trial subtraction is non-negative exactly when shifted value >= divisor
    assign o_q_bit = (w_shift >= {1'b0, i_dvs});

    // On success the true difference is below the divisor, so WIDTH-bit
    // modular subtraction yields it exactly; otherwise restore the shift.
    assign o_rem = o_q_bit ? (w_shift[WIDTH-1:0] - i_dvs) : w_shift[WIDTH-1:0];

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative radix-2 restoring divider for the execute stage.
//               Returns {remainder, quotient}; signed (DIV) or unsigned
//               (DIVU) selected by 'sign'. Fixed WIDTH+1 cycle latency.
//               Optional macro DIV_EARLY_OUT_EN: divide-by-zero and
//               |a| < |b| complete one cycle after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign,
    input  logic               opn_valid,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [2*WIDTH-1:0] result
);

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
    // All-ones quotient for divide by zero (DIV_ZERO_QUOT at 32 bits)
    localparam logic [WIDTH-1:0] c_zero_quot = {WIDTH{1'b1}};

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_dvd;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]   r_a_raw;    // original dividend for the divide-by-zero result
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_b_zero;
    logic               r_res_valid;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero_in;
    logic [WIDTH-1:0]   w_new_rem;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;
    logic [2*WIDTH-1:0] w_final;

    // Operand magnitudes only matter for signed divides
    assign w_a_mag     = (sign && a[WIDTH-1]) ? -a : a;
    assign w_b_mag     = (sign && b[WIDTH-1]) ? -b : b;
    assign w_b_zero_in = (b == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[WIDTH-1]),
        .i_dvs     (r_dvs),
        .o_rem     (w_new_rem),
        .o_q_bit   (w_q_bit)
    );

    // Final-iteration values, sign-corrected: quotient negative when operand
    // signs differ, remainder follows the dividend. -MIN/-1 wraps to MIN.
    assign w_q_mag = {r_dvd[WIDTH-2:0], w_q_bit};
    assign w_q_fix = r_q_neg ? -w_q_mag : w_q_mag;
    assign w_r_fix = r_r_neg ? -w_new_rem : w_new_rem;
    assign w_final = r_b_zero ? {r_a_raw, c_zero_quot} : {w_r_fix, w_q_fix};

`ifdef DIV_EARLY_OUT_EN
    logic w_small;
    assign w_small = (w_a_mag < w_b_mag);
`endif

    // Divider FSM: accept in IDLE, one quotient bit per cycle in CALC,
    // hold the result in DONE until the consumer takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_a_raw     <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_b_zero    <= 1'b0;
            r_res_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (opn_valid) begin
                        r_dvd    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_a_raw  <= a;
                        r_q_neg  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_r_neg  <= sign & a[WIDTH-1];
                        r_b_zero <= w_b_zero_in;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (w_b_zero_in) begin
                            r_result    <= {a, c_zero_quot};
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_small) begin
                            r_result    <= {a, {WIDTH{1'b0}}};
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    r_rem <= w_new_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_result    <= w_final;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign result    = r_result;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Self-checking bench for div_iter. Directed cases followed by
//               randomized operations checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

`ifdef DIV_EARLY_OUT_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        opn_valid;
    logic        res_ready;
    logic        res_valid;
    logic [63:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    div_iter u_dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .opn_valid (opn_valid),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating division in 64-bit arithmetic
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx;
        longint sy;
        longint q;
        longint r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic longint mag(input logic [31:0] x, input logic s);
        longint v;
        v = s ? longint'($signed(x)) : longint'({32'd0, x});
        return (v < 0) ? -v : v;
    endfunction

    // Cycles from the accepting edge (counted as 1) until res_valid is seen
    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (c_early && ((y == 32'd0) || (mag(x, s) < mag(y, s)))) return 1;
        return 33;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one op, waits for completion, applies
    // 'hold' cycles of backpressure, then completes the handshake and
    // returns at the negedge after the handshake edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                          input int hold, input string tag);
        logic [63:0] exp;
        int          lat;
        bit          seen;
        exp       = ref_div(ta, tb, ts);
        a         = ta;
        b         = tb;
        sign      = ts;
        opn_valid = 1'b1;
        res_ready = (hold == 0);
        @(posedge clk);
        #1;
        opn_valid = 1'b0;
        a         = $urandom;
        b         = $urandom;
        sign      = 1'($urandom_range(0, 1));
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 100) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(ta, tb, ts)));
        chk({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            chk({tag, "_hold_res"}, result, exp);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_drop_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_keep_res"}, result, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          mode;

        rst       = 1'b1;
        a         = '0;
        b         = '0;
        sign      = 1'b0;
        opn_valid = 1'b0;
        res_ready = 1'b0;
        #3;
        chk("reset_valid", 64'(res_valid), 64'd0);
        chk("reset_result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd100, 32'd7, 1'b0, 0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_min_m1");
        run_op(32'd5, 32'd0, 1'b0, 0, "u5_0");
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, 1, "s_neg_0");
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 5, "bp_ffff_10");
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, "u_big_dvs");

        // Flush mid-divide: outputs clear without waiting for a clock edge
        a         = 32'd1000;
        b         = 32'd3;
        sign      = 1'b0;
        opn_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        opn_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("flush_valid", 64'(res_valid), 64'd0);
        chk("flush_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd9, 32'd3, 1'b0, 0, "post_flush_9_3");

        run_op(32'd3, 32'd10, 1'b0, 0, "u3_10");
        run_op(32'hFFFF_FFFD, 32'd10, 1'b1, 0, "s_m3_10");

        for (int k = 0; k < 24; k++) begin
            mode = int'($urandom_range(0, 7));
            rs   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom;
            if (mode == 0) rb = 32'd0;
            else if (mode <= 2) rb = 32'($urandom_range(1, 300)) ^ (rs ? {32{rb[31]}} : 32'd0);
            else if (mode == 3) ra = 32'($urandom_range(0, 50));
            run_op(ra, rb, rs, int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire
